// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared types, limits and one-hot helper for the phase sequencer and control decoder
package phase_seq_pkg;
  typedef enum logic {RUN, HALT} seq_state_t;
  localparam int MAX_PHASES = 16;
  function automatic logic [MAX_PHASES-1:0] onehot_of(input logic [3:0] idx, input int n);
    return (int'(idx) < n) ? MAX_PHASES'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/phase_onehot_dec.sv
// phase_onehot_dec: binary phase index to one-hot decoder with force-zero override
module phase_onehot_dec #(
  parameter int N = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [PW-1:0] idx,
  input  logic          force_zero,
  output logic [N-1:0]  oh
);
  for (genvar i = 0; i < N; i++) begin : g_oh
    assign oh[i] = !force_zero && idx == PW'(i);
  end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: N-phase instruction cycle with stall, early termination and boundary halt
// Optional completed-instruction counter enabled by PHASE_SEQ_INSTR_COUNT_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int PW = $clog2(NUM_PHASES),
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  jump_first,
  input  logic                  halt_req,
  output logic [PW-1:0]         phase_idx,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic                  is_first,
  output logic                  is_last,
  output logic                  wrap,
  output logic                  halted
`ifdef PHASE_SEQ_INSTR_COUNT_EN
  ,output logic [CNT_W-1:0]     instr_count
`endif
);
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  seq_state_t state, state_n;
  logic [PW-1:0] phase_n;
  logic boundary;
  assign boundary = state == RUN && en && (jump_first || phase_idx == LAST);
  always_comb begin
    state_n = state;
    phase_n = phase_idx;
    if (state == HALT) begin
      state_n = halt_req ? HALT : RUN;
      phase_n = '0;
    end else if (en) begin
      state_n = boundary && halt_req ? HALT : RUN;
      phase_n = boundary ? '0 : phase_idx + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= RUN;
      phase_idx <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      phase_idx <= phase_n;
      wrap      <= boundary;
    end
`ifdef PHASE_SEQ_INSTR_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) instr_count <= '0;
    else if (boundary) instr_count <= instr_count + 1'b1;
`endif
  assign halted   = state == HALT;
  assign is_first = !halted && phase_idx == '0;
  assign is_last  = !halted && phase_idx == LAST;
  phase_onehot_dec #(.N(NUM_PHASES), .PW(PW)) u_dec (
    .idx(phase_idx),
    .force_zero(halted),
    .oh(phase_oh)
  );
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the Nibbler two-phase fetch/execute toggler. Generates an N-phase instruction cycle with stall, early termination and halt at instruction boundaries. Outputs the phase as both a binary index and one-hot. Feeds the control decoder, which gates register/memory strobes per phase.

Parameters:
NUM_PHASES, 2, phases per instruction cycle; legal range 2..16. A value of 2 reproduces the legacy fetch/execute toggle.
PW, $clog2(NUM_PHASES), width of phase_idx. Derived; do not override.
CNT_W, 8, width of instr_count. Used only with PHASE_SEQ_INSTR_COUNT_EN.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance enable; when 0 all state holds (stall)
jump_first  input  1  end the current instruction early; next phase is 0
halt_req  input  1  request halt at the next instruction boundary; level-sensitive
phase_idx  output  PW  current phase number, 0..NUM_PHASES-1
phase_oh  output  NUM_PHASES  one-hot of phase_idx; all zeros while halted
is_first  output  1  phase_idx==0 and not halted
is_last  output  1  phase_idx==NUM_PHASES-1 and not halted
wrap  output  1  registered one-cycle pulse after an instruction boundary is taken
halted  output  1  sequencer is in HALT state
instr_count  output  CNT_W  completed-instruction count; present only with the macro

Behaviour:
- Reset (asynchronous assert; deassert synchronised by the system):
  - state=RUN, phase_idx=0, phase_oh=1, is_first=1, is_last=0, wrap=0, halted=0, instr_count=0.
- States: RUN, HALT.
- RUN with en=1, each edge:
  - jump_first=1, or phase_idx==NUM_PHASES-1, is a boundary:
    - phase_idx<=0 and wrap<=1.
    - If halt_req=1 at that edge: state<=HALT, halted<=1.
  - Otherwise: phase_idx<=phase_idx+1, wrap<=0.
- RUN with en=0: all registers hold, except wrap<=0.
  - halt_req and jump_first are ignored while stalled.
- jump_first while phase_idx==0: still a boundary. The instruction counts as completed and phase stays 0.
- HALT:
  - phase_idx=0, phase_oh=0, is_first=0, is_last=0.
  - halt_req=0 at an edge (en is don't-care): state<=RUN and phase_idx stays 0. Phase 1 is reached no earlier than the second edge after release.
  - jump_first is ignored.
- Simultaneous jump_first and halt_req at a non-last phase: the boundary is taken and the halt is honoured on the same edge.
- Latency: all outputs are registered or decoded from registers. No combinational path from any input to any output.
- phase_idx never takes a value >= NUM_PHASES. Wrap-around is explicit, not modulo 2^PW.
- Reset asserted mid-instruction or in HALT forces the reset values immediately, independent of clk.

Optional Feature:
PHASE_SEQ_INSTR_COUNT_EN
- Defined: instr_count increments on every boundary edge (i.e. each edge that sets wrap<=1).
  - Wraps modulo 2^CNT_W.
  - Holds in HALT and while en=0.
- Undefined: the instr_count port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package phase_seq_pkg holds:
  - typedef enum logic {RUN, HALT} seq_state_t
  - localparam MAX_PHASES=16
  - function onehot_of(idx, n)
- Sub-module phase_onehot_dec: combinational PW-to-NUM_PHASES decoder with a force-zero input driven by halted. It is reused by the control decoder.

Test Plan:
- NUM_PHASES=2: reset 10 cycles, release, en=1 -> phase_idx toggles 0,1,0,1; wrap pulses on every second edge; is_first/is_last alternate.
- NUM_PHASES=5, en=1: 12 edges -> phase_idx 0,1,2,3,4,0,1,2,3,4,0,1; with the macro, instr_count=2. Then en=0 for 3 edges -> all state frozen and wrap=0.
- NUM_PHASES=4: jump_first at phase 1 -> next phase 0 and wrap=1. jump_first again at phase 0 -> phase stays 0 and wrap pulses again.
- NUM_PHASES=4: halt_req raised at phase 1 -> phases 2,3 complete, then halted=1, phase_oh=0. halt_req dropped -> halted=0 after one edge with phase 0, then phase 1 on the next edge.
- jump_first and halt_req together at phase 2 -> halted=1 on that edge and wrap=1. Async reset at mid-phase 3 between clock edges -> outputs reach reset values before the next edge.
